// File: rtl/mux_4to1_rr_arbiter.sv
// rtl/mux_4to1_rr_arbiter.sv - round-robin arbiter sharing a registered 4:1 bit mux
// Grants one of four requesters at a time, bounded by HOLD_CYCLES per grant.
module mux_4to1_rr_arbiter #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] req_in,
    input  logic [3:0] d_in,
    output logic [3:0] gnt_out,
    output logic [1:0] sel_out,
    output logic       busy_out,
    output logic       y_out,
    output logic       valid_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               y_q, y_d;
    logic               valid_q, valid_d;
    logic               release_w;
    logic               busy_w;

    // Circular search starting at ptr+1; ptr itself is checked last.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k + 1);
            if (req[idx]) begin
                pick = idx;
            end
        end
    endfunction

    assign busy_w    = (state_q == GRANT);
    assign release_w = ~req_in[sel_q] | (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        y_d        = busy_w ? d_in[sel_q] : 1'b0;
        valid_d    = busy_w;

        case (state_q)
            IDLE: begin
                if (req_in != 4'b0000) begin
                    state_d    = GRANT;
                    sel_d      = pick(req_in, last_ptr_q);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!release_w) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end else begin
                    // The released requester drops to lowest priority for the re-pick.
                    last_ptr_d = sel_q;
                    hold_cnt_d = '0;
                    if (req_in != 4'b0000) begin
                        sel_d = pick(req_in, sel_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            last_ptr_q <= 2'd3;
            hold_cnt_q <= '0;
            y_q        <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
        end
    end

    assign busy_out  = busy_w;
    assign sel_out   = sel_q;
    assign gnt_out   = busy_w ? (4'b0001 << sel_q) : 4'b0000;
    assign y_out     = y_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// tb/tb_mux_4to1_rr_arbiter.sv - directed vector bench for mux_4to1_rr_arbiter
module tb_mux_4to1_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       y;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    mux_4to1_rr_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
        .clk_in   (clk),
        .rst_in   (rst),
        .req_in   (req),
        .d_in     (d),
        .gnt_out  (gnt),
        .sel_out  (sel),
        .busy_out (busy),
        .y_out    (y),
        .valid_out(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] dd,
                                input logic [3:0] g, input logic [1:0] s, input logic b,
                                input logic yy, input logic v);
        vec_t e;
        e.rst = r; e.req = q; e.d = dd; e.gnt = g; e.sel = s; e.busy = b; e.y = yy; e.valid = v;
        vecs.push_back(e);
    endfunction

    initial begin
        int idx_exp;
        logic [3:0] dpat;
        logic       y_exp;

        // rst req    d        gnt    sel busy y v
        add(1, 4'hF, 4'h0,    4'h0, 0, 0, 0, 0);   // reset held two cycles
        add(1, 4'hF, 4'h0,    4'h0, 0, 0, 0, 0);
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 0, 0);   // single requester 2
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);   // hold expiry, re-granted
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);
        add(0, 4'h4, 4'h0,    4'h4, 2, 1, 0, 1);
        add(0, 4'h0, 4'h0,    4'h0, 2, 0, 0, 1);   // drop -> idle, sel holds
        add(0, 4'h0, 4'h0,    4'h0, 2, 0, 0, 0);
        add(0, 4'h2, 4'h2,    4'h2, 1, 1, 0, 0);   // grant on 1
        add(0, 4'hA, 4'h2,    4'h2, 1, 1, 1, 1);
        add(0, 4'hA, 4'h2,    4'h2, 1, 1, 1, 1);
        add(0, 4'h8, 4'h8,    4'h8, 3, 1, 0, 1);   // early release to 3
        add(0, 4'h9, 4'h9,    4'h8, 3, 1, 1, 1);
        add(0, 4'h9, 4'h9,    4'h8, 3, 1, 1, 1);
        add(0, 4'h9, 4'h9,    4'h8, 3, 1, 1, 1);
        add(0, 4'h9, 4'h9,    4'h1, 0, 1, 1, 1);   // wrap: 0 after 3
        add(0, 4'h9, 4'h1,    4'h1, 0, 1, 1, 1);
        add(0, 4'h9, 4'h1,    4'h1, 0, 1, 1, 1);
        add(0, 4'h9, 4'h1,    4'h1, 0, 1, 1, 1);
        add(0, 4'h9, 4'h1,    4'h8, 3, 1, 1, 1);   // then 3
        add(0, 4'h9, 4'h0,    4'h8, 3, 1, 0, 1);
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 0, 1);   // 3 released, 2 granted
        add(0, 4'h4, 4'h4,    4'h4, 2, 1, 1, 1);
        add(1, 4'h4, 4'h4,    4'h0, 0, 0, 0, 0);   // mid-grant reset
        add(0, 4'h5, 4'h1,    4'h1, 0, 1, 0, 0);   // priority restarts at 0
        add(0, 4'h5, 4'h1,    4'h1, 0, 1, 1, 1);

        rst = 1'b1; req = 4'h0; d = 4'h0;
        #2;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; d = vecs[i].d;
            @(posedge clk); #1;
            check("gnt",   i, gnt,          vecs[i].gnt);
            check("sel",   i, {2'b00, sel}, {2'b00, vecs[i].sel});
            check("busy",  i, {3'b0, busy}, {3'b0, vecs[i].busy});
            check("y",     i, {3'b0, y},    {3'b0, vecs[i].y});
            check("valid", i, {3'b0, valid},{3'b0, vecs[i].valid});
        end

        // Round robin with all four requesting: 0,1,2,3,0 four cycles each.
        rst = 1'b1; req = 4'hF; d = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        dpat = 4'b0101;
        d = dpat;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            idx_exp = (k / 4) % 4;
            check("rr_gnt",  100 + k, gnt, 4'b0001 << idx_exp);
            check("rr_busy", 100 + k, {3'b0, busy}, 4'h1);
            if (k == 0) y_exp = 1'b0;
            else        y_exp = dpat[((k - 1) / 4) % 4];
            check("rr_y",    100 + k, {3'b0, y}, {3'b0, y_exp});
        end

        req = 4'h0;
        @(posedge clk); #1;
        check("rr_idle", 200, gnt, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
